// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared trellis constants, state index type and traceback FSM states.
package viterbi_pkg;
    localparam int STATE_REG_NUM = 8;
    localparam int STATE_NUM = 2 ** STATE_REG_NUM;
    localparam int TB_DEPTH = 64;
    typedef logic [STATE_REG_NUM-1:0] state_t;
    typedef enum logic [1:0] {IDLE, TRACE, FLUSH} tb_state_e;
endpackage

// File: rtl/traceback_unit_if.sv
// traceback_unit_if: survivor input and decoded-bit output bundle of the traceback unit.
interface traceback_unit_if;
    import viterbi_pkg::*;
    logic i_sync;
    logic i_valid;
    state_t [STATE_NUM-1:0] i_bck_prv_st;
    state_t i_start_st;
    logic o_busy;
    logic o_bit;
    logic o_bit_valid;
    logic o_done;
    modport master (
        output i_sync, i_valid, i_bck_prv_st, i_start_st,
        input  o_busy, o_bit, o_bit_valid, o_done
    );
    modport slave (
        input  i_sync, i_valid, i_bck_prv_st, i_start_st,
        output o_busy, o_bit, o_bit_valid, o_done
    );
endinterface

// File: rtl/lifo_bitstack.sv
// lifo_bitstack: DEPTH-entry single-bit stack; reverses the traceback bit order.
module lifo_bitstack #(
    parameter int DEPTH = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic empty,
    output logic full
);
    localparam int PW = $clog2(DEPTH) + 1;
    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0] ptr_q;
    logic [PW-2:0] top_idx;
    // Low pointer bits minus one wrap to DEPTH-1 when full, so no wide index is needed.
    assign top_idx = ptr_q[PW-2:0] - 1'b1;
    assign dout = mem_q[top_idx];
    assign empty = ptr_q == '0;
    assign full = ptr_q == PW'(DEPTH);
    always_ff @(posedge clk) begin
        if (!rst) ptr_q <= '0;
        else if (push && !full) ptr_q <= ptr_q + 1'b1;
        else if (pop && !empty) ptr_q <= ptr_q - 1'b1;
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem_q[ptr_q[PW-2:0]] <= din;
    end
    assert property (@(posedge clk) disable iff (!rst) !(push && full));
    assert property (@(posedge clk) disable iff (!rst) !(pop && empty));
endmodule

// File: rtl/traceback_unit.sv
// traceback_unit: walks TB_DEPTH survivor steps back and emits the decoded bits oldest-first.
// BEST_STATE_EN defined: trace starts from i_start_st; otherwise from state 0.
module traceback_unit
    import viterbi_pkg::*;
(
    input logic clk,
    input logic rst,
    traceback_unit_if.slave tif
);
    localparam int CW = $clog2(TB_DEPTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(TB_DEPTH - 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    tb_state_e state_q, state_d;
    state_t cur_st_q, cur_st_d, start_st, nxt_st;
    logic [CW-1:0] step_cnt_q, step_cnt_d;
    logic bit_q, bit_d, bit_valid_q, bit_valid_d, done_q, done_d;
    logic push, pop, lifo_dout, lifo_unused_empty, lifo_unused_full;
`ifdef BEST_STATE_EN
    assign start_st = tif.i_start_st;
`else
    logic unused_start;
    assign unused_start = ^tif.i_start_st;
    assign start_st = '0;
`endif
    // The start cycle already consumes step 1, indexed by the start state.
    assign nxt_st = tif.i_bck_prv_st[state_q == IDLE ? start_st : cur_st_q];
    lifo_bitstack #(.DEPTH(TB_DEPTH)) u_lifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .din(nxt_st[STATE_REG_NUM-1]),
        .dout(lifo_dout),
        .empty(lifo_unused_empty),
        .full(lifo_unused_full)
    );
    always_comb begin
        state_d = state_q;
        cur_st_d = cur_st_q;
        step_cnt_d = step_cnt_q;
        push = 1'b0;
        pop = 1'b0;
        bit_d = 1'b0;
        bit_valid_d = 1'b0;
        done_d = 1'b0;
        case (state_q)
            IDLE: if (tif.i_sync && tif.i_valid) begin
                cur_st_d = nxt_st;
                push = 1'b1;
                step_cnt_d = ONE;
                state_d = TRACE;
            end
            TRACE: if (tif.i_valid) begin
                cur_st_d = nxt_st;
                push = 1'b1;
                step_cnt_d = step_cnt_q + 1'b1;
                state_d = step_cnt_q == LAST ? FLUSH : TRACE;
            end
            FLUSH: begin
                pop = 1'b1;
                bit_d = lifo_dout;
                bit_valid_d = 1'b1;
                step_cnt_d = step_cnt_q - 1'b1;
                done_d = step_cnt_q == ONE;
                state_d = step_cnt_q == ONE ? IDLE : FLUSH;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cur_st_q <= '0;
            step_cnt_q <= '0;
            bit_q <= 1'b0;
            bit_valid_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_st_q <= cur_st_d;
            step_cnt_q <= step_cnt_d;
            bit_q <= bit_d;
            bit_valid_q <= bit_valid_d;
            done_q <= done_d;
        end
    end
    assign tif.o_busy = state_q != IDLE;
    assign tif.o_bit = bit_q;
    assign tif.o_bit_valid = bit_valid_q;
    assign tif.o_done = done_q;
endmodule

// File: tb/tb_traceback_unit.sv
// tb_traceback_unit: scoreboard bench; a trellis walk model queues expected bits per block.
module tb_traceback_unit;
    import viterbi_pkg::*;
    typedef struct packed {logic b; logic d;} exp_t;
    localparam state_t START = 8'hA5;
    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t q[$];
    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int exp_done = 0;
    traceback_unit_if tif();
    traceback_unit dut (.clk(clk), .rst(rst), .tif(tif.slave));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic state_t surv(input int mode, input int k, input state_t s);
        case (mode)
            1: return {k[0], s[STATE_REG_NUM-1:1]};
            2: return {s[0], s[STATE_REG_NUM-1:1]};
            default: return '0;
        endcase
    endfunction
    task automatic fill(input int mode, input int k);
        for (int s = 0; s < STATE_NUM; s++) tif.i_bck_prv_st[s] = surv(mode, k, state_t'(s));
    endtask
    always @(negedge clk) begin
        if (rst && tif.o_bit_valid) begin
            if (q.size() == 0) check("spurious_bit", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                check("bit", tif.o_bit, e.b);
                check("done", tif.o_done, e.d);
            end
        end
        if (rst && tif.o_done && !tif.o_bit_valid) check("done_without_valid", 1, 0);
        if (rst && tif.o_done) done_cnt++;
    end
    task automatic run_block(input int mode, input bit stall, input int kill_at, input bit hold, input bit pre);
        state_t cur;
        logic bits [TB_DEPTH];
`ifdef BEST_STATE_EN
        cur = START;
`else
        cur = '0;
`endif
        for (int k = 0; k < TB_DEPTH; k++) begin
            if (k == 0 && pre) check("b2b_start_busy", tif.o_busy, 1);
            else begin
                if (stall && k > 0 && k % 8 == 0) repeat (3) begin
                    tif.i_valid = 1'b0;
                    for (int s = 0; s < STATE_NUM; s++) tif.i_bck_prv_st[s] = state_t'($urandom);
                    @(posedge clk); #1;
                    check("stall_busy", tif.o_busy, 1);
                end
                if (k == kill_at) begin
                    rst = 1'b0;
                    tif.i_valid = 1'b0;
                    tif.i_sync = 1'b0;
                    @(posedge clk); #1;
                    check("kill_busy", tif.o_busy, 0);
                    check("kill_bit_valid", tif.o_bit_valid, 0);
                    check("kill_done", tif.o_done, 0);
                    check("kill_bit", tif.o_bit, 0);
                    rst = 1'b1;
                    return;
                end
                fill(mode, k);
                tif.i_sync = 1'b1;
                tif.i_valid = 1'b1;
                @(posedge clk); #1;
            end
            cur = surv(mode, k, cur);
            bits[k] = cur[STATE_REG_NUM-1];
        end
        if (hold) fill(mode, 0);
        tif.i_sync = hold;
        tif.i_valid = hold;
        check("flush_busy", tif.o_busy, 1);
        for (int j = TB_DEPTH - 1; j >= 0; j--) q.push_back('{b: bits[j], d: j == 0});
        exp_done++;
        if (hold) begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!tif.o_done && t < 400);
            check("b2b_done_seen", tif.o_done, 1);
            @(posedge clk); #1;
        end
    endtask
    task automatic wait_idle();
        int t = 0;
        while (q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", q.size(), 0);
        @(posedge clk); #1;
        check("idle_busy", tif.o_busy, 0);
    endtask
    initial begin
        tif.i_sync = 1'b0;
        tif.i_valid = 1'b0;
        tif.i_start_st = START;
        fill(0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", tif.o_busy, 0);
        check("rst_bit", tif.o_bit, 0);
        check("rst_bit_valid", tif.o_bit_valid, 0);
        check("rst_done", tif.o_done, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        run_block(0, 0, -1, 0, 0);
        wait_idle();
        run_block(1, 0, -1, 0, 0);
        wait_idle();
        run_block(1, 1, -1, 0, 0);
        wait_idle();
        run_block(1, 0, 30, 0, 0);
        run_block(1, 0, -1, 0, 0);
        wait_idle();
        run_block(2, 0, -1, 0, 0);
        wait_idle();
        run_block(1, 0, -1, 1, 0);
        run_block(1, 0, -1, 0, 1);
        wait_idle();
        check("done_pulses", done_cnt, exp_done);
        check("leftover_expected", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
